// File: rtl/divider_datapath_if.sv
// Purpose : bundles the divider control-to-datapath strobes, operands, status flags and results.
// Latency : wiring only; the timing belongs to the datapath that uses this bundle.
// Backpres: none; the control unit paces every step, so there is no stall path.
// Ports   : master (control unit / bench) drives operands and strobes and reads flags/results;
//           slave (datapath) reads operands and strobes and drives flags/results.
interface divider_datapath_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
);
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             ld, ud, ce;
   logic             ldx, slx, srx, cex;
   logic             ldr, slr, srr, cer;
   logic             s1, s2, s3;
   logic             done;
   logic             r_lt_y;
   logic             count_equ_0;
   logic             y_eq_0;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;

   modport master (
      output dividend, divisor, ld, ud, ce, ldx, slx, srx, cex,
             ldr, slr, srr, cer, s1, s2, s3, done,
      input  r_lt_y, count_equ_0, y_eq_0, count, quotient, remainder
   );

   modport slave (
      input  dividend, divisor, ld, ud, ce, ldx, slx, srx, cex,
             ldr, slr, srr, cer, s1, s2, s3, done,
      output r_lt_y, count_equ_0, y_eq_0, count, quotient, remainder
   );
endinterface

// File: rtl/divider_datapath.sv
// Purpose : restoring-divider datapath; holds X (dividend/quotient), R (remainder), Y (divisor), the counter and the result.
// Latency : register effects appear one clock after the strobe; the flags are combinational from the current registers.
// Backpres: none; it obeys the control strobes on every edge, and the result holds until the next done or rst.
// Ports   : clk, rst (async, active high); bus = divider_datapath_if slave (operands, strobes, flags, count, results).
module divider_datapath #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
) (
   input logic                clk,
   input logic                rst,
   divider_datapath_if.slave  bus
);

   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;

   // R is one bit wider than Y, so the shifted partial remainder (< 2*Y) always fits.
   logic [WIDTH:0]   r_minus_y;
   logic [WIDTH:0]   r_shift_src;

   assign r_minus_y   = r_q - {1'b0, y_q};
   assign r_shift_src = bus.s3 ? r_minus_y : r_q;

   always_comb begin
      count_d = count_q;
      if (bus.ld) begin
         count_d = CNT_W'(WIDTH);
      end else if (bus.ce) begin
         count_d = bus.ud ? (count_q + CNT_W'(1)) : (count_q - CNT_W'(1));
      end
   end

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (bus.cex) begin
         x_d = '0;
      end else if (bus.ldx) begin
         x_d = bus.dividend;
         y_d = bus.divisor;
      end else if (bus.slx) begin
         x_d = {x_q[WIDTH-2:0], bus.s1};
      end else if (bus.srx) begin
         x_d = {1'b0, x_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      r_d = r_q;
      if (bus.cer) begin
         r_d = '0;
      end else if (bus.ldr) begin
         r_d = bus.s2 ? r_minus_y : '0;
      end else if (bus.slr) begin
         // Uses the pre-edge X MSB, so a paired slx/slr moves that bit from X into R in one step.
         r_d = {r_shift_src[WIDTH-1:0], x_q[WIDTH-1]};
      end else if (bus.srr) begin
         r_d = {1'b0, r_q[WIDTH:1]};
      end
   end

   always_comb begin
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      if (bus.done) begin
         quotient_d  = x_q;
         remainder_d = r_q[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q         <= '0;
         y_q         <= '0;
         r_q         <= '0;
         count_q     <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         r_q         <= r_d;
         count_q     <= count_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   assign bus.r_lt_y      = (r_q < {1'b0, y_q});
   assign bus.count_equ_0 = (count_q == '0);
   assign bus.y_eq_0      = (y_q == '0);
   assign bus.count       = count_q;
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;

endmodule

// File: tb/tb_divider_datapath.sv
module tb_divider_datapath;

   logic clk = 1'b0;
   logic rst = 1'b0;

   divider_datapath_if #(.WIDTH(4), .CNT_W(4)) bus ();

   divider_datapath #(.WIDTH(4), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int a;
      int b;
      int q;
      int r;
   } exp_t;

   exp_t sb_q[$];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Result monitor: a done strobe sampled on an edge means the result registers have updated by the falling edge.
   always @(posedge clk) begin
      if (bus.done === 1'b1 && rst === 1'b0) begin
         @(negedge clk);
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got q=%0d r=%0d, expected no result", bus.quotient, bus.remainder);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk($sformatf("quot_%0d_div_%0d", e.a, e.b), int'(bus.quotient), e.q);
            chk($sformatf("rem_%0d_div_%0d", e.a, e.b), int'(bus.remainder), e.r);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic clear_strobes();
      bus.ld = 0; bus.ud = 0; bus.ce = 0;
      bus.ldx = 0; bus.slx = 0; bus.srx = 0; bus.cex = 0;
      bus.ldr = 0; bus.slr = 0; bus.srr = 0; bus.cer = 0;
      bus.s1 = 0; bus.s2 = 0; bus.s3 = 0; bus.done = 0;
   endtask

   // Inputs change 1 time unit after the rising edge; checks also happen there.
   task automatic step();
      @(posedge clk);
      #1;
      clear_strobes();
   endtask

   task automatic div_run(input int a, input int b, input int q, input int r, input bit trace);
      int exp_r[4] = '{3, 6, 5, 2};
      exp_t e;
      e.a = a; e.b = b; e.q = q; e.r = r;
      sb_q.push_back(e);
      bus.dividend = 4'(a);
      bus.divisor  = 4'(b);
      bus.ld = 1; bus.ldx = 1; bus.ldr = 1; bus.s2 = 0;
      step();
      if (trace) begin
         chk("load_x", int'(dut.x_q), 13);
         chk("load_y", int'(dut.y_q), 4);
         chk("load_r", int'(dut.r_q), 0);
         chk("load_count", int'(bus.count), 4);
         chk("load_r_lt_y", int'(bus.r_lt_y), 1);
      end
      bus.slx = 1; bus.slr = 1; bus.s1 = 0; bus.s3 = 0;
      step();
      for (int i = 0; i < 4; i++) begin
         bus.ce = 1; bus.ud = 0; bus.slx = 1; bus.slr = 1;
         bus.s1 = ~bus.r_lt_y;
         bus.s3 = ~bus.r_lt_y;
         step();
         if (trace) chk($sformatf("iter%0d_r", i), int'(dut.r_q), exp_r[i]);
      end
      bus.srr = 1;
      step();
      if (trace) begin
         chk("srr_r", int'(dut.r_q), 1);
         chk("final_count", int'(bus.count), 0);
      end
      bus.done = 1;
      step();
   endtask

   initial begin
      bus.dividend = 0;
      bus.divisor  = 0;
      clear_strobes();

      // Flags while reset is held.
      rst = 1;
      #3;
      chk("rst_count_equ_0", int'(bus.count_equ_0), 1);
      chk("rst_y_eq_0", int'(bus.y_eq_0), 1);
      chk("rst_r_lt_y", int'(bus.r_lt_y), 0);
      @(negedge clk);
      rst = 0;
      step();

      // Full 13/4 with per-iteration trace.
      div_run(13, 4, 3, 1, 1'b1);
      step();
      chk("hold_q_before_rst", int'(bus.quotient), 3);

      // Async reset mid-division with X=13, count=2.
      bus.dividend = 13; bus.divisor = 4;
      bus.ld = 1; bus.ldx = 1; bus.ldr = 1;
      step();
      bus.ce = 1; step();
      bus.ce = 1; step();
      chk("pre_rst_x", int'(dut.x_q), 13);
      chk("pre_rst_count", int'(bus.count), 2);
      #2;
      rst = 1;
      #1;
      chk("arst_x", int'(dut.x_q), 0);
      chk("arst_y", int'(dut.y_q), 0);
      chk("arst_r", int'(dut.r_q), 0);
      chk("arst_count", int'(bus.count), 0);
      chk("arst_quotient", int'(bus.quotient), 0);
      chk("arst_remainder", int'(bus.remainder), 0);
      chk("arst_count_equ_0", int'(bus.count_equ_0), 1);
      @(negedge clk);
      rst = 0;
      step();

      // Counter: load, count down to zero, wrap, count up, load over enable.
      bus.ld = 1; step();
      chk("cnt_ld", int'(bus.count), 4);
      for (int i = 0; i < 4; i++) begin
         bus.ce = 1; bus.ud = 0; step();
         chk($sformatf("cnt_equ0_edge%0d", i + 1), int'(bus.count_equ_0), (i == 3) ? 1 : 0);
      end
      bus.ce = 1; bus.ud = 0; step();
      chk("cnt_wrap_down", int'(bus.count), 15);
      bus.ce = 1; bus.ud = 1; step();
      chk("cnt_wrap_up", int'(bus.count), 0);
      bus.ce = 1; bus.ud = 1; step();
      chk("cnt_up", int'(bus.count), 1);
      bus.ld = 1; bus.ce = 1; bus.ud = 1; step();
      chk("cnt_ld_over_ce", int'(bus.count), 4);

      // Capture and hold: a new ldx after done must not disturb the result.
      div_run(13, 4, 3, 1, 1'b0);
      bus.dividend = 7; bus.divisor = 2; bus.ldx = 1;
      step();
      step();
      chk("hold_quotient", int'(bus.quotient), 3);
      chk("hold_remainder", int'(bus.remainder), 1);

      // Divide by zero: every step subtracts zero, so quotient is all ones and R ends as the dividend.
      div_run(13, 0, 15, 13, 1'b0);
      chk("div0_y_eq_0", int'(bus.y_eq_0), 1);

      // Exhaustive at WIDTH=4.
      for (int a = 0; a < 16; a++) begin
         for (int b = 1; b < 16; b++) begin
            div_run(a, b, a / b, a % b, 1'b0);
         end
      end

      step();
      step();
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
